// File: rtl/note_tone_gen.sv
// Note tone generator: picks the lowest selected note, tracks the octave from
// the button edges and divides clk down to a 50% duty square wave.
module note_tone_gen #(
  parameter int unsigned SIM_SHIFT = 0,
  parameter int unsigned OCT_RESET = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] note_switches,
  input  logic       inc_octave,
  input  logic       dec_octave,
  output logic       audio_out,
  output logic       tone_active,
  output logic [2:0] note_idx,
  output logic [2:0] octave
);

  localparam int unsigned HALF_W  = 20;
  localparam int unsigned NOTE_W  = 3;
  localparam int unsigned OCT_W   = 3;
  localparam int unsigned NUM_SW  = 7;
  localparam logic [OCT_W-1:0] OCT_MIN = OCT_W'(2);
  localparam logic [OCT_W-1:0] OCT_MAX = OCT_W'(6);
  localparam logic [OCT_W-1:0] OCT_MID = OCT_W'(4);

  logic [NOTE_W-1:0] note_idx_q, note_idx_d;
  logic [OCT_W-1:0]  octave_q, octave_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              audio_q, audio_d;
  logic              tone_active_q, tone_active_d;
  logic              inc_prev_q, inc_prev_d;
  logic              dec_prev_q, dec_prev_d;

  logic [HALF_W-1:0] base_c;
  logic [HALF_W-1:0] base_shift_c;
  logic [HALF_W-1:0] half_c;
  logic [HALF_W-1:0] half_m1_c;
  logic              inc_edge_c;
  logic              dec_edge_c;
  logic              cfg_change_c;

  // Octave-4 half-period of the registered note, scaled to the registered octave
  always_comb begin
    base_c = '0;
    case (note_idx_q)
      NOTE_W'(1): base_c = HALF_W'(191113);
      NOTE_W'(2): base_c = HALF_W'(170262);
      NOTE_W'(3): base_c = HALF_W'(151686);
      NOTE_W'(4): base_c = HALF_W'(143173);
      NOTE_W'(5): base_c = HALF_W'(127553);
      NOTE_W'(6): base_c = HALF_W'(113636);
      NOTE_W'(7): base_c = HALF_W'(101239);
      default:    base_c = '0;
    endcase
    base_shift_c = base_c >> SIM_SHIFT;
    if (octave_q >= OCT_MID) begin
      half_c = base_shift_c >> (octave_q - OCT_MID);
    end else begin
      half_c = base_shift_c << (OCT_MID - octave_q);
    end
    half_m1_c = half_c - HALF_W'(1);
  end

  // Next note, octave, divider counter and speaker level
  always_comb begin
    note_idx_d    = '0;
    octave_d      = octave_q;
    cnt_d         = '0;
    audio_d       = 1'b0;
    inc_prev_d    = inc_octave;
    dec_prev_d    = dec_octave;
    inc_edge_c    = inc_octave & ~inc_prev_q;
    dec_edge_c    = dec_octave & ~dec_prev_q;

    // Ascending scan: higher bits (lower pitch) overwrite, so C wins
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      if (note_switches[i]) begin
        note_idx_d = NOTE_W'(NUM_SW - i);
      end
    end
    tone_active_d = (note_idx_d != '0);

    if (inc_edge_c && !dec_edge_c && (octave_q < OCT_MAX)) begin
      octave_d = octave_q + OCT_W'(1);
    end else if (dec_edge_c && !inc_edge_c && (octave_q > OCT_MIN)) begin
      octave_d = octave_q - OCT_W'(1);
    end

    cfg_change_c = (note_idx_d != note_idx_q) || (octave_d != octave_q);

    if (cfg_change_c || !tone_active_q) begin
      cnt_d   = '0;
      audio_d = 1'b0;
    end else if (cnt_q >= half_m1_c) begin
      cnt_d   = '0;
      audio_d = ~audio_q;
    end else begin
      cnt_d   = cnt_q + HALF_W'(1);
      audio_d = audio_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      note_idx_q    <= '0;
      octave_q      <= OCT_W'(OCT_RESET);
      cnt_q         <= '0;
      audio_q       <= 1'b0;
      tone_active_q <= 1'b0;
      inc_prev_q    <= 1'b0;
      dec_prev_q    <= 1'b0;
    end else begin
      note_idx_q    <= note_idx_d;
      octave_q      <= octave_d;
      cnt_q         <= cnt_d;
      audio_q       <= audio_d;
      tone_active_q <= tone_active_d;
      inc_prev_q    <= inc_prev_d;
      dec_prev_q    <= dec_prev_d;
    end
  end

  assign audio_out   = audio_q;
  assign tone_active = tone_active_q;
  assign note_idx    = note_idx_q;
  assign octave      = octave_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: per-cycle comparison against a phase-based model
// plus directed period / octave expectations.
module tb_note_tone_gen;

  localparam int unsigned SIM_SHIFT = 10;
  localparam int unsigned OCT_RESET = 4;
  localparam int          TMO       = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] note_switches;
  logic       inc_octave;
  logic       dec_octave;
  logic       audio_out;
  logic       tone_active;
  logic [2:0] note_idx;
  logic [2:0] octave;

  int n_tests = 0;
  int n_fail  = 0;

  note_tone_gen #(.SIM_SHIFT(SIM_SHIFT), .OCT_RESET(OCT_RESET)) dut (
    .clk(clk), .rst(rst), .note_switches(note_switches),
    .inc_octave(inc_octave), .dec_octave(dec_octave),
    .audio_out(audio_out), .tone_active(tone_active),
    .note_idx(note_idx), .octave(octave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: note/octave from the rules, audio from elapsed cycles since config
  int base_tab [8] = '{0, 191113, 170262, 151686, 143173, 127553, 113636, 101239};

  function automatic int m_half(input int n, input int o);
    int b;
    b = base_tab[n] >> SIM_SHIFT;
    if (o >= 4) return b / (1 << (o - 4));
    else        return b * (1 << (4 - o));
  endfunction

  int m_note = 0;
  int m_oct  = 0;
  int m_p    = 0;
  bit m_inc_prev = 0;
  bit m_dec_prev = 0;
  bit m_valid    = 0;

  always @(posedge clk) begin
    int nn;
    int no;
    bit ie;
    bit de;
    if (!rst) begin
      m_note = 0; m_oct = OCT_RESET; m_p = 0;
      m_inc_prev = 0; m_dec_prev = 0; m_valid = 1;
    end else begin
      nn = 0;
      for (int i = 0; i < 7; i++)
        if (nn == 0 && note_switches[6-i]) nn = i + 1;
      ie = inc_octave && !m_inc_prev;
      de = dec_octave && !m_dec_prev;
      no = m_oct;
      if (ie && !de) no = (m_oct >= 6) ? 6 : m_oct + 1;
      if (de && !ie) no = (m_oct <= 2) ? 2 : m_oct - 1;
      if (nn != m_note || no != m_oct) m_p = 0;
      else if (m_note != 0)            m_p = m_p + 1;
      else                             m_p = 0;
      m_note = nn; m_oct = no;
      m_inc_prev = inc_octave; m_dec_prev = dec_octave;
    end
  end

  // Compare every cycle once the model has seen reset
  always @(negedge clk) begin
    int exp_audio;
    if (m_valid) begin
      exp_audio = (m_note != 0) && (((m_p / m_half(m_note, m_oct)) % 2) == 1);
      check("audio_out", int'(audio_out), exp_audio);
      check("tone_active", int'(tone_active), int'(m_note != 0));
      check("note_idx", int'(note_idx), m_note);
      check("octave", int'(octave), m_oct);
    end
  end

  // High and low lengths of the next full audio cycle; -1 on timeout
  task automatic measure(output int hi, output int lo);
    int t;
    int h;
    int l;
    t = 0; h = 0; l = 0; hi = -1; lo = -1;
    while (audio_out !== 1'b0 && t < TMO) begin @(negedge clk); t++; end
    while (audio_out !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    while (audio_out === 1'b1 && t < TMO) begin @(negedge clk); t++; h++; end
    while (audio_out === 1'b0 && t < TMO) begin @(negedge clk); t++; l++; end
    if (t < TMO) begin hi = h; lo = l; end
  endtask

  task automatic wait_high(input string name);
    int t;
    t = 0;
    while (audio_out !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    check(name, int'(audio_out === 1'b1), 1);
  endtask

  task automatic pulse_inc(input int n);
    inc_octave = 1'b1;
    repeat (n) @(negedge clk);
    inc_octave = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int hi;
    int lo;
    rst = 1'b0; note_switches = '0; inc_octave = 1'b0; dec_octave = 1'b0;

    check("pin A4 half", m_half(6, 4), 110);
    check("pin C4 half", m_half(1, 4), 186);
    check("pin B4 half", m_half(7, 4), 98);
    check("pin A5 half", m_half(6, 5), 55);
    check("pin A6 half", m_half(6, 6), 27);

    repeat (3) @(negedge clk);
    check("reset octave", int'(octave), 4);
    check("reset note_idx", int'(note_idx), 0);
    check("reset audio", int'(audio_out), 0);
    check("reset tone_active", int'(tone_active), 0);

    // 1: A4
    rst = 1'b1;
    note_switches = 7'b0000010;
    @(negedge clk);
    check("A note_idx", int'(note_idx), 6);
    check("A tone_active", int'(tone_active), 1);
    measure(hi, lo);
    check("A4 high", hi, 110);
    check("A4 low", lo, 110);

    // 2: C and A -> C wins
    note_switches = 7'b1000010;
    @(negedge clk);
    check("C+A note_idx", int'(note_idx), 1);
    measure(hi, lo);
    check("C4 high", hi, 186);
    check("C4 low", lo, 186);

    // 3: octave up, then saturate
    note_switches = 7'b0000010;
    repeat (3) @(negedge clk);
    pulse_inc(50);
    check("oct up", int'(octave), 5);
    measure(hi, lo);
    check("A5 high", hi, 55);
    check("A5 low", lo, 55);
    pulse_inc(5);
    check("oct 6", int'(octave), 6);
    pulse_inc(5);
    pulse_inc(5);
    check("oct sat", int'(octave), 6);
    measure(hi, lo);
    check("A6 high", hi, 27);
    check("A6 low", lo, 27);

    // 4: down one, then both buttons together
    dec_octave = 1'b1;
    repeat (5) @(negedge clk);
    dec_octave = 1'b0;
    repeat (5) @(negedge clk);
    check("oct down", int'(octave), 5);
    repeat (7) @(negedge clk);
    inc_octave = 1'b1; dec_octave = 1'b1;
    repeat (5) @(negedge clk);
    inc_octave = 1'b0; dec_octave = 1'b0;
    repeat (5) @(negedge clk);
    check("oct both", int'(octave), 5);

    // 5: release mid-high
    wait_high("high before release");
    repeat (10) @(negedge clk);
    note_switches = '0;
    @(negedge clk);
    check("release audio", int'(audio_out), 0);
    check("release tone_active", int'(tone_active), 0);
    check("release note_idx", int'(note_idx), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("silent audio", int'(audio_out), 0);
    end

    // 6: reset while playing at octave 6
    note_switches = 7'b0000010;
    pulse_inc(5);
    check("oct 6 again", int'(octave), 6);
    wait_high("high before reset");
    rst = 1'b0;
    @(negedge clk);
    check("rst audio", int'(audio_out), 0);
    check("rst note_idx", int'(note_idx), 0);
    check("rst octave", int'(octave), 4);
    check("rst tone_active", int'(tone_active), 0);
    rst = 1'b1;
    @(negedge clk);
    check("post-rst note_idx", int'(note_idx), 6);
    measure(hi, lo);
    check("post-rst high", hi, 110);
    check("post-rst low", lo, 110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
